// File: rtl/demux1to4_32bit.sv
// demux1to4_32bit: registered 1-to-4 demultiplexer for 32-bit words.
// One valid/ready input stream is steered into four single-entry output
// slots, each with its own valid/ready handshake.
// Optional feature macro: DEMUX_RR_EN (round-robin destination pointer
// replaces sel; default build uses sel).
module demux1to4_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  sel,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic [31:0] out3,
  output logic [31:0] out4,
  output logic [7:0]  xfer_count
);

  logic [1:0]  dest;
  logic        accept;
  logic [3:0]  fill;
  logic [3:0]  drain;
  logic [31:0] slot_data [4];

`ifdef DEMUX_RR_EN
  logic [1:0] rr_ptr;
  logic       unused_sel;

  assign unused_sel = ^sel;
  assign dest       = rr_ptr;

  // Round-robin pointer advances on every accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign dest = sel;
`endif

  // Ready and per-slot fill/drain strobes for the current cycle.
  always_comb begin
    in_ready = !out_valid[dest] || out_ready[dest];
    accept   = in_valid && in_ready;
    fill     = '0;
    drain    = out_valid & out_ready;
    if (accept) begin
      fill[dest] = 1'b1;
    end
  end

  // Slot valid bits: a refill in the same cycle as a drain keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
    end else begin
      out_valid <= fill | (out_valid & ~drain);
    end
  end

  // Slot data registers load only on fill and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        slot_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (fill[k]) begin
          slot_data[k] <= in_data;
        end
      end
    end
  end

  // Accepted-word counter, wraps modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 8'd1;
    end
  end

  assign out1 = slot_data[0];
  assign out2 = slot_data[1];
  assign out3 = slot_data[2];
  assign out4 = slot_data[3];

endmodule

// File: tb/tb_demux1to4_32bit.sv
// Scoreboard bench for demux1to4_32bit. Stimulus pushes expected words into
// per-slot queues; a monitor pops them on each output handshake.
// Honours DEMUX_RR_EN in its reference model.
module tb_demux1to4_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out1, out2, out3, out4;
  logic [7:0]  xfer_count;

  demux1to4_32bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] exp_q [4][$];
  logic [31:0] last_data [4];
  int          acc_count;
  int          rr_ptr;
  logic        exp_ready;
  logic        accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot_out(input int k);
    case (k)
      0: return out1;
      1: return out2;
      2: return out3;
      default: return out4;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_data[k] = 32'h0;
    end
    acc_count = 0;
    rr_ptr    = 0;
    exp_ready = 1'b1;
  endtask

  // One bus cycle: drive inputs after the edge and record the expected outcome.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] s, input logic [3:0] r);
    int dst;
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    sel       = s;
    out_ready = r;
`ifdef DEMUX_RR_EN
    dst = rr_ptr;
`else
    dst = int'(s);
`endif
    exp_ready = (exp_q[dst].size() == 0) || r[dst];
    accepted  = v && exp_ready;
    if (accepted) begin
      exp_q[dst].push_back(d);
      last_data[dst] = d;
      acc_count = (acc_count + 1) % 256;
      rr_ptr    = (rr_ptr + 1) % 4;
    end
  endtask

  // Monitor: registered state after each edge, handshakes at mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]},
              {31'b0, exp_q[k].size() != 0});
          chk($sformatf("out%0d_data", k + 1), slot_out(k), last_data[k]);
        end
        chk("xfer_count", {24'b0, xfer_count}, acc_count[31:0]);
      end
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("unexpected_delivery_out%0d", k + 1), slot_out(k), 32'hxxxxxxxx);
            end else begin
              chk($sformatf("delivered_out%0d", k + 1), slot_out(k), exp_q[k].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_out1", out1, 32'h0);
    chk("rst_out2", out2, 32'h0);
    chk("rst_out3", out3, 32'h0);
    chk("rst_out4", out4, 32'h0);
    chk("rst_xfer_count", {24'b0, xfer_count}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
  endtask

  initial begin
    logic        v;
    logic [31:0] d;
    logic [1:0]  s;
    logic [3:0]  r;
    logic        stalled;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    out_ready = '0;
    model_clear();
    #1;
    check_reset_values();
    #20;
    rst_n = 1'b1;

    // Routing with all consumers ready
    cyc(1'b1, 32'hAFAFAFAF, 2'b00, 4'b1111);
    cyc(1'b1, 32'h0767A631, 2'b01, 4'b1111);
    cyc(1'b1, 32'hCDCDCDCD, 2'b10, 4'b1111);
    cyc(1'b1, 32'hFDFDEBEB, 2'b11, 4'b1111);
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);

    // Backpressure on slot 3
    cyc(1'b1, 32'h11111111, 2'b10, 4'b1011);
    cyc(1'b1, 32'h22222222, 2'b10, 4'b1011);
    cyc(1'b1, 32'h22222222, 2'b10, 4'b1011);
    cyc(1'b1, 32'h22222222, 2'b10, 4'b1111);
    cyc(1'b1, 32'h33333333, 2'b00, 4'b1011);
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);

    // Simultaneous drain and refill of slot 1
    cyc(1'b1, 32'hAAAA0001, 2'b00, 4'b0000);
    cyc(1'b1, 32'hBBBB0002, 2'b00, 4'b0001);
    cyc(1'b0, 32'h0, 2'b00, 4'b0000);
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);

    // Counter wrap: 257 back-to-back accepted words
    for (int i = 0; i < 257; i++) begin
      cyc(1'b1, $urandom, 2'($urandom_range(0, 3)), 4'b1111);
    end
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);

    // Randomized traffic obeying the producer hold rule
    stalled = 1'b0;
    d = '0;
    s = '0;
    for (int i = 0; i < 600; i++) begin
      if (!stalled) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        s = 2'($urandom_range(0, 3));
      end
      r = 4'($urandom);
      cyc(v, d, s, r);
      stalled = v && !exp_ready;
    end

    // Asynchronous reset in the middle of a cycle with slots occupied
    cyc(1'b1, 32'h5A5A5A5A, 2'b01, 4'b0000);
    cyc(1'b1, 32'hA5A5A5A5, 2'b11, 4'b0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_clear();
    check_reset_values();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Resume after reset
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, $urandom, 2'($urandom_range(0, 3)), 4'($urandom));
      if (!exp_ready) begin
        cyc(1'b0, 32'h0, 2'b00, 4'b1111);
      end
    end
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);
    cyc(1'b0, 32'h0, 2'b00, 4'b1111);
    @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to4_32bit.md
# demux1to4_32bit

Registered 1-to-4 demultiplexer for 32-bit words. It takes one valid/ready input stream and steers each accepted word into one of four single-entry output slots, each with its own valid/ready handshake. It is the distribution-side counterpart of the 4-to-1 32-bit selector and sits between a single producer and four consumers, such as datapath lanes or write-back ports.

## Interface
Parameters: none; widths are fixed at 32 data bits and 4 destinations.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts a word this cycle (combinational)
- in_data  input  32  word to route
- sel  input  2  destination index; 00→out1, 01→out2, 10→out3, 11→out4
- out_valid  output  4  bit k set: slot k+1 holds an undelivered word
- out_ready  input  4  bit k set: consumer k+1 takes the word this cycle
- out1, out2, out3, out4  output  32 each  slot data registers
- xfer_count  output  8  count of accepted input words, modulo 256

## Operation
- Destination index d = sel, or the internal pointer when DEMUX_RR_EN is defined.
- in_ready = !out_valid[d] || out_ready[d]. The target slot must be empty or draining in the same cycle. Non-target slots never block.
- Accept: in_valid && in_ready. At the next edge:
  - outd+1 ← in_data
  - out_valid[d] ← 1
  - xfer_count ← xfer_count + 1, wrapping 255→0
- Drain: out_valid[k] && out_ready[k] clears out_valid[k] at the next edge, unless slot k is refilled in that same cycle, in which case it stays 1 and the data updates.
- out_ready[k] while out_valid[k]=0 has no effect.
- Slot data registers hold their last value after a drain. Only out_valid qualifies them.
- Producer rule: while in_valid=1 and in_ready=0, the producer holds in_data and sel stable.
- All four slots can drain in the same cycle, independently.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=4'b0000
  - out1..out4=32'h0
  - xfer_count=8'h00
  - RR pointer=0
  - in_ready=1, because all slots are empty
- Latency: a word accepted at edge N appears on outd+1 with out_valid[d]=1 immediately after edge N.
- Throughput: one word per cycle whenever the target consumer holds out_ready high.
- in_ready depends combinationally on sel, out_valid and out_ready. There is no combinational path from in_valid.
- Reset asserted mid-transfer: pending words are discarded and all state is forced to reset values. Operation resumes on the first edge after rst_n rises.

## Configuration
- DEMUX_RR_EN defined:
  - sel is ignored.
  - A 2-bit internal pointer selects d.
  - The pointer advances 0→1→2→3→0 on each accepted word and holds otherwise.
  - in_ready follows slot[pointer].
- DEMUX_RR_EN undefined: d = sel and no pointer logic is built.

## Test plan
- Reset: assert rst_n=0 mid-run → out_valid=0000, out1..out4=0, xfer_count=00, in_ready=1 asynchronously, without waiting for a clock edge.
- Routing, with out_ready=1111:
  - Send AFAFAFAF/sel=00, 0767A631/sel=01, CDCDCDCD/sel=10, FDFDEBEB/sel=11 on consecutive cycles.
  - Required: each value appears on out1..out4 in turn, with a one-cycle out_valid pulse on bits 0,1,2,3.
  - xfer_count=04 at the end.
- Backpressure:
  - With out_ready[2]=0, send 11111111/sel=10, then 22222222/sel=10 → in_ready=0, out3 stays 11111111, xfer_count increments only once.
  - A concurrent 33333333/sel=00 is accepted.
  - Raising out_ready[2] then admits 22222222 on that cycle.
- Simultaneous drain and refill: slot 1 holds AAAA0001; assert out_ready[0]=1 together with an accepted BBBB0002/sel=00 → out_valid[0] stays 1 and out1=BBBB0002 next cycle.
- Counter wrap: 256 accepted words → xfer_count returns to 00. The 257th word → 01.
- DEMUX_RR_EN build:
  - Hold sel=11 and send 5 words with out_ready=1111 → they land in out1, out2, out3, out4, out1.
  - Stall slot 2 → in_ready=0 and the pointer holds at 1.
